tmr_crc_checker_pipe: RTL
=========================

# tmr_crc_checker_pipe

Pipelined, self-monitoring successor to the combinational TMR CRC checker. Three `crc_checker` replicas decode each accepted codeword, and a voter compares their full `{fflag, dout}` results. Per-replica disagreement counters permanently mask a replica that reaches a fault threshold, which degrades the block from triple to dual mode. It sits between the CRC-protected link receiver and the neuron datapath, with valid/ready flow control on both sides.

## Interface
- `N`, 16, payload width
- `CL`, 8, CRC width; codeword is `N+CL` bits
- `CNT_W`, 4, width of each disagreement counter (saturating)
- `FAULT_THR`, 3, disagreement count that masks a replica; 0 disables masking
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  codeword valid
- `in_ready`  out  1  block can accept a codeword
- `din`  in  N+CL  codeword
- `inj_err`  in  3  test hook; bit k XORs bit 0 of replica k's `dout`
- `clr`  in  1  synchronous clear of counters, mask and `unres_cnt`
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts the result
- `dout`  out  N  voted payload
- `fflag`  out  1  voted CRC-fail flag
- `invalid`  out  1  vote unresolved
- `rep_mask`  out  3  bit k set means replica k is excluded
- `dual`  out  1  exactly one replica is masked
- `err_cnt`  out  3*CNT_W  per-replica disagreement counts; replica k is at `[k*CNT_W +: CNT_W]`
- `unres_cnt`  out  CNT_W  saturating count of unresolved votes

## Operation
- Accept condition: `acc = in_valid & in_ready`.
- Ready rule: `in_ready = !out_valid | out_ready`.
- Replica result: `r_k = {fflag_k, dout_k ^ inj_err[k]}`.
- TRIPLE mode (`rep_mask == 0`):
  - All three agree: output `r_0`, counters unchanged.
  - Exactly one replica dissents: output the majority value and increment the dissenter's `err_cnt`.
  - All three differ: output `r_0`, assert `invalid`, increment `unres_cnt`.
- DUAL mode (one replica masked):
  - The two active replicas agree: output their value.
  - They disagree: output the lower-index active replica, assert `invalid`, increment `unres_cnt`. No `err_cnt` changes.
  - A masked replica's result is ignored, and its counter is frozen.
- Masking:
  - In TRIPLE mode, when an increment makes `err_cnt[k] == FAULT_THR` (and `FAULT_THR != 0`), set `rep_mask[k]` on the same clock edge.
  - Only one replica can ever be masked, because masking happens only in TRIPLE mode.
- Counters saturate at `2^CNT_W - 1`.
- `clr` vs. `acc` in the same cycle:
  - `clr` wins for counters, mask and `unres_cnt`; all go to 0.
  - The beat is still voted using the pre-clear mask and produces output, but it causes no counter or mask update.
- `dual = |rep_mask`.

## Timing
- Reset values: `out_valid=0`, `dout=0`, `fflag=0`, `invalid=0`, `rep_mask=0`, `dual=0`, all `err_cnt=0`, `unres_cnt=0`.
- Latency: one cycle. A codeword accepted at edge t produces a result with `out_valid` asserted after edge t.
- The output register loads on `acc`.
- `out_valid` clears on `out_ready & !acc`.
- Under backpressure (`out_valid & !out_ready`), `dout`, `fflag` and `invalid` hold stable.
- Back-to-back throughput: 1 word/cycle while `out_ready` is held high.
- Counter, mask and `unres_cnt` updates occur on the accept edge, so they are visible in the same cycle the result appears.
- Reset mid-transfer drops the in-flight result; no partial state survives.

## Structure
- Package `tmr_pkg` holds:
  - `vote_e` (AGREE, MAJ0, MAJ1, MAJ2, UNRESOLVED)
  - `mode_e` (TRIPLE, DUAL)
  - helper function `sat_inc`
- Combinational sub-module `tmr_vote3`:
  - Inputs: three results and the mask.
  - Outputs: voted value, `vote_e`, dissenter one-hot.
- The top level holds the three `crc_checker` instances, the output register stage and the counters.

## Test plan
All scenarios use N=16, CL=8, FAULT_THR=3.
- Reset, then a valid codeword with payload 0xA5A5 and `out_ready=1` → next cycle `dout=0xA5A5`, `fflag=0`, `invalid=0`; all counters 0.
- `inj_err=3'b010` for 3 accepted beats → outputs correct each beat; `err_cnt[1]` reads 1, 2, 3; `rep_mask=3'b010` and `dual=1` after the 3rd beat.
- In DUAL mode (replica 1 masked), `inj_err=3'b001` for one beat → `invalid=1`, output taken from replica 0 (bit 0 flipped), `unres_cnt=1`, `err_cnt` unchanged.
- Hold `out_ready=0` for 4 cycles after one accept:
  - `in_ready=0`; `dout` stable.
  - Release → result consumed, next word accepted the same cycle.
- `clr` asserted in the same cycle as an accept with `inj_err=3'b100` → output voted correctly; all counters 0, `rep_mask=0` afterwards.
- Assert `rst_n=0` while `out_valid=1` with 2 replicas' counters nonzero → all outputs at reset values immediately (asynchronous).

Source files
------------

// File: rtl/tmr_pkg.sv
// Shared types and helpers for the pipelined TMR CRC checker.
package tmr_pkg;

  // MAJk means a two-against-one majority in which replica k is the dissenter.
  typedef enum logic [2:0] {AGREE, MAJ0, MAJ1, MAJ2, UNRESOLVED} vote_e;

  typedef enum logic {TRIPLE, DUAL} mode_e;

  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned max_v);
    return (v >= max_v) ? max_v : v + 1;
  endfunction

endpackage

// File: rtl/crc_checker.sv
// Combinational CRC checker: recomputes the CRC over the payload, MSB first, zero init,
// and flags a mismatch against the received CRC field in din[CL-1:0].
module crc_checker #(
  parameter int N = 16,
  parameter int CL = 8,
  parameter logic [CL-1:0] POLY = CL'(7)
) (
  input  logic [N+CL-1:0] din,
  output logic [N-1:0]    dout,
  output logic            fflag
);

  logic [CL-1:0] crc;

  // NOTE: blocking '=' is correct here; each loop iteration must see the previous one's crc.
  always_comb begin
    crc = '0;
    for (int i = N - 1; i >= 0; i--) begin
      crc = {crc[CL-2:0], 1'b0} ^ ({CL{crc[CL-1] ^ din[CL+i]}} & POLY);
    end
  end

  assign dout  = din[N+CL-1:CL];
  assign fflag = (crc != din[CL-1:0]);

endmodule

// File: rtl/tmr_vote3.sv
// Three-way voter with replica masking; in dual mode the lower-index active replica wins ties.
module tmr_vote3
  import tmr_pkg::*;
#(
  parameter int W = 17
) (
  input  logic [W-1:0] r0,
  input  logic [W-1:0] r1,
  input  logic [W-1:0] r2,
  input  logic [2:0]   mask,
  output logic [W-1:0] vout,
  output vote_e        vote,
  output logic [2:0]   dissent
);

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    vout    = r0;
    vote    = AGREE;
    dissent = '0;
    case (mask)
      3'b000: begin
        if (r0 == r1) begin
          if (r0 != r2) begin
            vote    = MAJ2;
            dissent = 3'b100;
          end
        end else if (r1 == r2) begin
          vout    = r1;
          vote    = MAJ0;
          dissent = 3'b001;
        end else if (r0 == r2) begin
          vote    = MAJ1;
          dissent = 3'b010;
        end else begin
          vote = UNRESOLVED;
        end
      end
      3'b001: begin
        vout = r1;
        if (r1 != r2) vote = UNRESOLVED;
      end
      3'b010: if (r0 != r2) vote = UNRESOLVED;
      3'b100: if (r0 != r1) vote = UNRESOLVED;
      default: vote = UNRESOLVED;
    endcase
  end

endmodule

// File: rtl/tmr_crc_checker_pipe.sv
// Pipelined TMR CRC checker: three replicas, a voter, one output register stage with
// valid/ready, and per-replica fault counters that mask a persistently dissenting replica.
module tmr_crc_checker_pipe
  import tmr_pkg::*;
#(
  parameter int N = 16,
  parameter int CL = 8,
  parameter int CNT_W = 4,
  parameter int FAULT_THR = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N+CL-1:0]    din,
  input  logic [2:0]         inj_err,
  input  logic               clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       dout,
  output logic               fflag,
  output logic               invalid,
  output logic [2:0]         rep_mask,
  output logic               dual,
  output logic [3*CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0]   unres_cnt
);

  localparam int W = N + 1;
  localparam int unsigned CNT_MAX = (2 ** CNT_W) - 1;

  logic [2:0][W-1:0]     res;
  logic [W-1:0]          vout;
  vote_e                 vote;
  logic [2:0]            dissent;
  mode_e                 mode;
  logic                  acc;
  logic [2:0][CNT_W-1:0] cnt_q, cnt_inc;
  logic [CNT_W-1:0]      unres_q, unres_inc;
  logic [2:0]            mask_q;

  for (genvar k = 0; k < 3; k++) begin : g_rep
    logic [N-1:0] pay;
    logic         ff;
    crc_checker #(.N(N), .CL(CL)) u_crc (.din(din), .dout(pay), .fflag(ff));
    assign res[k] = {ff, pay ^ {{(N-1){1'b0}}, inj_err[k]}};
  end

  tmr_vote3 #(.W(W)) u_vote (
    .r0(res[0]), .r1(res[1]), .r2(res[2]), .mask(mask_q),
    .vout(vout), .vote(vote), .dissent(dissent)
  );

  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;
  assign mode     = (|mask_q) ? DUAL : TRIPLE;
  assign dual     = (mode == DUAL);
  assign rep_mask = mask_q;
  assign err_cnt  = cnt_q;
  assign unres_cnt = unres_q;

  always_comb begin
    for (int k = 0; k < 3; k++) cnt_inc[k] = CNT_W'(sat_inc(32'(cnt_q[k]), CNT_MAX));
    unres_inc = CNT_W'(sat_inc(32'(unres_q), CNT_MAX));
  end

  // NOTE: registers use non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      dout      <= '0;
      fflag     <= 1'b0;
      invalid   <= 1'b0;
    end else if (acc) begin
      out_valid      <= 1'b1;
      {fflag, dout}  <= vout;
      invalid        <= (vote == UNRESOLVED);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Clear outranks an accept; the voted beat still goes out but leaves no trace here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      unres_q <= '0;
      mask_q  <= '0;
    end else if (clr) begin
      cnt_q   <= '0;
      unres_q <= '0;
      mask_q  <= '0;
    end else if (acc) begin
      if (vote == UNRESOLVED) unres_q <= unres_inc;
      for (int k = 0; k < 3; k++) begin
        if (dissent[k]) begin
          cnt_q[k] <= cnt_inc[k];
          if (FAULT_THR != 0 && int'(cnt_inc[k]) == FAULT_THR) mask_q[k] <= 1'b1;
        end
      end
    end
  end

endmodule
